// File: rtl/food_map_loader_pkg.sv
// Shared constants, state encoding and tile addressing for the food-map loader.
package food_pkg;

  localparam int unsigned COLS       = 28;
  localparam int unsigned ROWS       = 29;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned TILES      = ROWS * COLS;

  typedef enum logic [2:0] {
    LOAD,
    TAIL,
    RUN,
    RD,
    CHK,
    CLR
  } food_state_t;

  // Row-major tile index; operands are already ADDR_W wide so 811 fits untruncated.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] tx,
                                                   input logic [ADDR_W-1:0] ty);
    return ty * ADDR_W'(COLS) + tx;
  endfunction

endpackage

// File: rtl/food_map_loader_if.sv
// Layout-ROM read port plus food-RAM read/write ports seen by the loader.
interface food_map_loader_if;
  import food_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;

  modport master (
    output rom_addr,
    input  rom_data,
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/food_map_loader.sv
// Loads the pellet layout into the food RAM, then clears the Pacman tile's
// pellet once per frame and tracks how many pellets remain.
module food_map_loader
  import food_pkg::*;
(
  input  logic                 clock,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic [9:0]           PacmanX,
  input  logic [9:0]           PacmanY,
  food_map_loader_if.master    mem,
  output logic                 busy,
  output logic                 eat_pulse,
  output logic [ADDR_W-1:0]    pellets_left,
  output logic                 finish
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TILES - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROWS_A   = ADDR_W'(ROWS);

  food_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] idx_dly_q, idx_dly_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pel_q, pel_d;
  logic              fin_q, fin_d;

  logic [ADDR_W-1:0] tx, ty;
  logic              in_range;
  logic              unused_pix;

  assign tx         = ADDR_W'(PacmanX[9:TILE_SHIFT]);
  assign ty         = ADDR_W'(PacmanY[9:TILE_SHIFT]);
  assign in_range   = (tx < COLS_A) && (ty < ROWS_A);
  assign unused_pix = ^{PacmanX[TILE_SHIFT-1:0], PacmanY[TILE_SHIFT-1:0]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    idx_dly_d = idx_dly_q;
    vld_d     = 1'b0;
    addr_d    = addr_q;
    pel_d     = pel_q;

    // The delayed load slot lines up with ROM data for the previous idx.
    if (vld_q && mem.rom_data) begin
      pel_d = pel_q + 1'b1;
    end

    case (state_q)
      LOAD: begin
        vld_d     = 1'b1;
        idx_dly_d = idx_q;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = TAIL;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      TAIL: state_d = RUN;
      RUN: begin
        if (frame_tick && in_range) begin
          addr_d  = tile_addr(tx, ty);
          state_d = RD;
        end
      end
      RD:  state_d = CHK;
      CHK: state_d = mem.rd_data ? CLR : RUN;
      CLR: begin
        state_d = RUN;
        if (pel_q != '0) begin
          pel_d = pel_q - 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase

    if (start) begin
      state_d = LOAD;
      idx_d   = '0;
      vld_d   = 1'b0;
      pel_d   = '0;
    end

    fin_d = (state_d inside {RUN, RD, CHK, CLR}) && (pel_d == '0);
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      idx_dly_q <= '0;
      vld_q     <= 1'b0;
      addr_q    <= '0;
      pel_q     <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      idx_dly_q <= idx_dly_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      pel_q     <= pel_d;
      fin_q     <= fin_d;
    end
  end

  assign mem.rom_addr = idx_q;
  assign mem.rd_addr  = addr_q;
  assign mem.wr_en    = vld_q || (state_q == CLR);
  assign mem.wr_addr  = (state_q == CLR) ? addr_q : idx_dly_q;
  assign mem.wr_data  = vld_q & mem.rom_data;

  assign busy         = (state_q == LOAD) || (state_q == TAIL);
  assign eat_pulse    = (state_q == CLR);
  assign pellets_left = pel_q;
  assign finish       = fin_q;

endmodule

// File: tb/tb_food_map_loader.sv
// Self-checking bench: timeline model of load/probe behaviour, ROM and RAM models.
module tb_food_map_loader;
  import food_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              frame_tick = 1'b0;
  logic [9:0]        px = '0;
  logic [9:0]        py = '0;
  logic              busy, eat, fin;
  logic [ADDR_W-1:0] pel;

  food_map_loader_if mif();

  food_map_loader dut (
    .clock       (clk),
    .Reset       (rst_n),
    .start       (start),
    .frame_tick  (frame_tick),
    .PacmanX     (px),
    .PacmanY     (py),
    .mem         (mif),
    .busy        (busy),
    .eat_pulse   (eat),
    .pellets_left(pel),
    .finish      (fin)
  );

  always #5 clk = ~clk;

  logic rom [1024];
  logic ram [1024];

  always @(posedge clk) begin
    mif.rom_data <= rom[mif.rom_addr];
    mif.rd_data  <= ram[mif.rd_addr];
    if (mif.wr_en) ram[mif.wr_addr] <= mif.wr_data;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: load timeline relative to its first cycle, probe timeline relative to the tick.
  int ls = 0;
  int pt = 0;
  int paddr = 0;
  int exp_pel = 0;
  bit pact = 1'b0;
  bit peat = 1'b0;
  bit food [1024];

  always @(negedge clk) begin
    automatic int d = cyc - ls;
    automatic int k = cyc - pt;
    automatic bit idle = !pact;
    automatic bit ewr = 1'b0;
    automatic int tx, ty;
    if (!rst_n) begin
      chk("rst_busy", int'(busy), 1);
      chk("rst_wr_en", int'(mif.wr_en), 0);
      chk("rst_pellets", int'(pel), 0);
      chk("rst_finish", int'(fin), 0);
      chk("rst_eat", int'(eat), 0);
      chk("rst_rom_addr", int'(mif.rom_addr), 0);
      ls = cyc + 1;
      pact = 1'b0;
      exp_pel = 0;
    end else begin
      if (d < TILES + 1) begin
        chk("ld_busy", int'(busy), 1);
        chk("ld_eat", int'(eat), 0);
        chk("ld_finish", int'(fin), 0);
        chk("ld_pellets", int'(pel), exp_pel);
        if (d < TILES) chk("ld_rom_addr", int'(mif.rom_addr), d);
        chk("ld_wr_en", int'(mif.wr_en), int'(d >= 1));
        if (d >= 1) begin
          chk("ld_wr_addr", int'(mif.wr_addr), d - 1);
          chk("ld_wr_data", int'(mif.wr_data), int'(rom[d-1]));
          exp_pel += int'(rom[d-1]);
          food[d-1] = rom[d-1];
        end
      end else begin
        if (pact && k == 1) chk("rd_addr", int'(mif.rd_addr), paddr);
        ewr = pact && k == 3 && peat;
        chk("run_busy", int'(busy), 0);
        chk("run_wr_en", int'(mif.wr_en), int'(ewr));
        chk("run_eat", int'(eat), int'(ewr));
        chk("run_pellets", int'(pel), exp_pel);
        chk("run_finish", int'(fin), int'(exp_pel == 0));
        if (ewr) begin
          chk("clr_wr_addr", int'(mif.wr_addr), paddr);
          chk("clr_wr_data", int'(mif.wr_data), 0);
          food[paddr] = 1'b0;
          exp_pel--;
        end
        if (pact && (k == 3 || (k == 2 && !peat))) pact = 1'b0;
      end
      if (start) begin
        ls = cyc + 1;
        pact = 1'b0;
        exp_pel = 0;
      end else if (d >= TILES + 1 && frame_tick && idle) begin
        tx = int'(px >> 4);
        ty = int'(py >> 4);
        if (tx < 28 && ty < 29) begin
          pact = 1'b1;
          pt = cyc;
          paddr = ty * 28 + tx;
          peat = food[paddr];
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick(input int x, input int y);
    step();
    px = 10'(x);
    py = 10'(y);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic probe_count(input int x, input int y, output int eats, output int wrs);
    tick(x, y);
    eats = 0;
    wrs = 0;
    repeat (4) begin
      @(negedge clk);
      eats += int'(eat);
      wrs += int'(mif.wr_en);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  function automatic int popcount_rom();
    int s = 0;
    for (int i = 0; i < 1024; i++) s += int'(rom[i]);
    return s;
  endfunction

  initial begin
    int n, w, e, wr, g;
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 1'b0;
      ram[i] = 1'b0;
    end
    rom[0] = 1'b1; rom[5] = 1'b1; rom[114] = 1'b1; rom[400] = 1'b1; rom[811] = 1'b1;

    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    w = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (mif.wr_en) w++;
      step();
      frame_tick = (c == 400);
    end
    frame_tick = 1'b0;
    chk("busy_cycles", n, 813);
    chk("load_writes", w, 812);
    chk("loaded_pellets", int'(pel), 5);
    chk("loaded_finish", int'(fin), 0);

    tick(32'h020, 32'h040);
    @(negedge clk);
    chk("probe_rd_addr", int'(mif.rd_addr), 114);
    @(negedge clk);
    @(negedge clk);
    chk("probe_wr_en", int'(mif.wr_en), 1);
    chk("probe_wr_addr", int'(mif.wr_addr), 114);
    chk("probe_wr_data", int'(mif.wr_data), 0);
    chk("probe_eat", int'(eat), 1);
    @(negedge clk);
    chk("probe_pellets", int'(pel), 4);

    probe_count(32'h020, 32'h040, e, wr);
    chk("reprobe_eats", e, 0);
    chk("reprobe_writes", wr, 0);
    chk("reprobe_pellets", int'(pel), 4);

    probe_count(32'h1C0, 32'h000, e, wr);
    chk("oob_x_writes", wr, 0);
    probe_count(32'h000, 32'h1D0, e, wr);
    chk("oob_y_writes", wr, 0);
    chk("oob_pellets", int'(pel), 4);

    step();
    px = '0;
    py = '0;
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    e = 0;
    repeat (6) begin
      @(negedge clk);
      e += int'(eat);
    end
    chk("double_tick_eats", e, 1);
    chk("double_tick_pellets", int'(pel), 3);

    probe_count(32'h050, 32'h000, e, wr);
    probe_count(32'h080, 32'h0E0, e, wr);
    chk("finish_before_last", int'(fin), 0);
    probe_count(32'h1B0, 32'h1C0, e, wr);
    chk("last_eat", e, 1);
    chk("finish_after_last", int'(fin), 1);
    chk("pellets_empty", int'(pel), 0);

    repeat (10) tick(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    repeat (4) step();

    px = 10'h020;
    py = 10'h040;
    start = 1'b1;
    frame_tick = 1'b1;
    step();
    start = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    chk("start_busy", int'(busy), 1);
    chk("start_finish", int'(fin), 0);
    chk("start_pellets", int'(pel), 0);
    wait_idle("reload_timeout");
    chk("reload_pellets", int'(pel), 5);

    step();
    start = 1'b1;
    step();
    start = 1'b0;
    g = 0;
    while (mif.rom_addr != 10'd300 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("reach_idx300", int'(mif.rom_addr), 300);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_pellets", int'(pel), 0);
    chk("midrst_wr_en", int'(mif.wr_en), 0);
    chk("midrst_rom_addr", int'(mif.rom_addr), 0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_rom_addr", int'(mif.rom_addr), 0);
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_idle("rst_reload_timeout");
    chk("rst_reload_pellets", int'(pel), 5);

    for (int i = 0; i < TILES; i++) rom[i] = ($urandom_range(0, 5) == 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("rand_load_timeout");
    @(negedge clk);
    chk("rand_pellets", int'(pel), popcount_rom());
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 4)) step();
      if ($urandom_range(0, 1) == 0)
        tick(int'($urandom_range(0, 27)) * 16 + int'($urandom_range(0, 15)),
             int'($urandom_range(0, 28)) * 16 + int'($urandom_range(0, 15)));
      else
        tick(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
